// File: rtl/adc_avg_filter.sv
// Boxcar averaging filter for 12-bit ADC panel-voltage samples over a 2^LOG2_DEPTH window.
// Optional spike rejection is compiled in with `define ADC_SPIKE_REJECT_EN.
module adc_avg_filter #(
   parameter int WIDTH      = 12,
   parameter int LOG2_DEPTH = 3,
   parameter int SPIKE_TH   = 512
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             sample_valid,
   input  logic [WIDTH-1:0] sample,
   output logic [WIDTH-1:0] v_out,
   output logic             v_valid,
   output logic             primed,
   output logic             spike_rej
);
   localparam int DEPTH = 1 << LOG2_DEPTH;
   localparam int SW    = WIDTH + LOG2_DEPTH;

   typedef enum logic {FILLING, RUNNING} state_t;

   state_t                state_q, state_d;
   logic [WIDTH-1:0]      buffer [DEPTH];
   logic [LOG2_DEPTH-1:0] ptr;
   logic [LOG2_DEPTH:0]   fill;
   logic [SW-1:0]         sum, sum_next;
   logic [WIDTH-1:0]      old;
   logic                  accept;

   // Until the window is full the slot being overwritten holds no counted data,
   // so the buffer never needs a reset.
   always_comb begin
      old      = primed ? buffer[ptr] : '0;
      sum_next = sum + SW'(sample) - SW'(old);
   end

`ifdef ADC_SPIKE_REJECT_EN
   logic [1:0]         rej;
   logic signed [WIDTH:0] diff;
   logic [WIDTH:0]     mag;
   logic               oob;
   logic               reject;

   always_comb begin
      diff   = $signed({1'b0, sample}) - $signed({1'b0, v_out});
      mag    = diff[WIDTH] ? $unsigned(-diff) : $unsigned(diff);
      oob    = primed && (mag > (WIDTH+1)'(SPIKE_TH));
      reject = sample_valid && oob && (rej != 2'd3);
      accept = sample_valid && !reject;
   end

   // A run of four out-of-band samples is treated as a real step and let through.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rej       <= '0;
         spike_rej <= 1'b0;
      end else begin
         spike_rej <= reject;
         if (reject)
            rej <= rej + 2'd1;
         else if (accept)
            rej <= '0;
      end
   end
`else
   logic unused_cfg;
   assign unused_cfg = ^SPIKE_TH;
   assign accept     = sample_valid;
   assign spike_rej  = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state_q <= FILLING;
      else
         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (state_q == FILLING && accept && fill == (LOG2_DEPTH+1)'(DEPTH-1))
         state_d = RUNNING;
   end

   always_comb begin
      primed = (state_q == RUNNING);
   end

   always_ff @(posedge clk) begin
      if (accept)
         buffer[ptr] <= sample;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr     <= '0;
         fill    <= '0;
         sum     <= '0;
         v_out   <= '0;
         v_valid <= 1'b0;
      end else begin
         v_valid <= 1'b0;
         if (accept) begin
            ptr <= ptr + 1'b1;
            sum <= sum_next;
            if (fill != (LOG2_DEPTH+1)'(DEPTH))
               fill <= fill + 1'b1;
            if (state_d == RUNNING) begin
               v_out   <= sum_next[SW-1:LOG2_DEPTH];
               v_valid <= 1'b1;
            end
         end
      end
   end
endmodule

// File: doc/adc_avg_filter.md
# adc_avg_filter

Conditions raw 12-bit panel-voltage samples from the ADC front end before they reach the voltage comparator and max-voltage register. Keeps a 2^LOG2_DEPTH-entry circular sample buffer and a running sum, and emits the boxcar average with a one-cycle valid strobe. This suppresses the sample-to-sample noise that would otherwise cause false "greater-than" hits during the servo sweep. Optionally rejects isolated spikes before they enter the average.

## Interface
- WIDTH, 12, sample and output width in bits.
- LOG2_DEPTH, 3, log2 of averaging window (default window = 8 samples).
- SPIKE_TH, 512, maximum allowed |sample − V_OUT| before a sample counts as a spike (used only with ADC_SPIKE_REJECT_EN).
- CLK  input  1  system clock, rising edge.
- RST_N  input  1  reset, asynchronous, active-low.
- SAMPLE_VALID  input  1  SAMPLE is valid this cycle; may be high every cycle.
- SAMPLE  input  WIDTH  raw unsigned ADC code.
- V_OUT  output  WIDTH  filtered voltage, registered.
- V_VALID  output  1  one-cycle pulse when V_OUT is updated.
- PRIMED  output  1  high once the window has been filled since reset.
- SPIKE_REJ  output  1  one-cycle pulse when a sample is discarded (tied 0 without the macro).

## Operation
- State: buffer[0..2^L−1], write pointer PTR (L bits, wraps 2^L−1→0), SUM (WIDTH+L bits, never overflows), fill counter FILL (L+1 bits, saturates at 2^L), and reject counter REJ (2 bits).
- Accepted sample s at PTR:
  - buffer[PTR] <= s
  - SUM <= SUM + s − old, where old = buffer[PTR] if PRIMED, otherwise 0. Because of this, the buffer itself needs no reset.
  - PTR <= PTR+1
  - FILL increments until it reaches 2^L.
- PRIMED = (FILL == 2^L).
- V_OUT <= SUM_next >> L, truncating. It updates only when an accepted sample makes or keeps PRIMED high.
- V_VALID pulses with each V_OUT update.
- Before priming, V_OUT holds 0 and V_VALID stays low.
- SAMPLE_VALID low: all state holds.
- States: FILLING (FILL < 2^L) → RUNNING on the 2^L-th accepted sample. Only reset returns the block to FILLING.

## Timing
- Latency: sample accepted at edge n produces V_OUT/V_VALID at edge n+1, so they are visible in the cycle after SAMPLE_VALID.
- Throughput: one sample per clock.
- Reset values:
  - V_OUT = 0
  - V_VALID = 0
  - PRIMED = 0
  - SPIKE_REJ = 0
  - SUM = 0, PTR = 0, FILL = 0, REJ = 0
- Reset asserted mid-window clears everything immediately, without waiting for a clock edge. After release the block re-primes from scratch and no stale buffer data contributes, because of the old = 0 rule.
- A sample on the same edge as reset release is ignored. The first accepted sample is the one at the first edge with RST_N high.

## Configuration
- Macro ADC_SPIKE_REJECT_EN.
- Defined, and only while PRIMED:
  - A sample with |SAMPLE − V_OUT| > SPIKE_TH is out-of-band.
  - If it is out-of-band and REJ < 3: the sample is discarded (no buffer, SUM, PTR or V_OUT change, no V_VALID), SPIKE_REJ pulses, and REJ increments.
  - The 4th consecutive out-of-band sample is accepted normally and clears REJ. This lets the filter track a genuine step.
  - Any in-band accepted sample clears REJ.
  - The difference is computed in WIDTH+1 bits signed.
- Not defined: every valid sample is accepted, REJ logic is absent, and SPIKE_REJ is tied 0.

## Test plan
- **Priming:** after reset, 8 samples of 1000 on consecutive cycles → PRIMED and V_VALID first high the cycle after the 8th sample; V_OUT = 1000; no V_VALID earlier.
- **Truncation/window slide:**
  - Samples 0..7 → V_OUT = 3 (sum 28 >> 3).
  - A 9th sample of 80 replaces 0 → sum 108 → V_OUT = 13.
- **Full scale and wrap:** 20 samples of 4095 → V_OUT = 4095 with no overflow; PTR wraps twice, confirmed by the correct average after pointer wrap with mixed data.
- **Gaps:** SAMPLE_VALID toggled 1,0,0,1 → state holds on idle cycles; V_VALID only follows valid cycles.
- **Reset mid-operation:** primed at 1000, assert RST_N = 0 between edges → outputs 0 asynchronously. Release, then 8 samples of 200 → V_OUT = 200, with no residue from 1000.
- **Spike reject (ADC_SPIKE_REJECT_EN, SPIKE_TH = 512):** primed at 1000.
  - A single 3000 → SPIKE_REJ pulse, V_OUT stays 1000, no V_VALID.
  - Four consecutive 3000 → three rejects, then the 4th is accepted → V_OUT = 1250.
  - Without the macro, the single 3000 → V_OUT = 1250.
